// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for the boot loader.
// The slave side is the loader. The master side is the byte source together with the memory.
interface imem_loader_if #(
  parameter int n = 32,
  parameter int r = 6
);
  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           byte_ready;
  logic           mem_we;
  logic [r-1:0]   mem_addr;
  logic [n-1:0]   mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. It packs a little-endian byte stream into n-bit words
// and writes them to consecutive addresses from 0. It releases the CPU once the load is done.
module imem_loader #(
  parameter int n = 32,
  parameter int r = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [r:0]    num_words,
  imem_loader_if.slave  bus,
  output logic [r:0]    word_count,
  output logic [n-1:0]  checksum,
  output logic          busy,
  output logic          done,
  output logic          cpu_run
);
  localparam int BPW = n / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);
  localparam logic [r:0]    DEPTH    = {1'b1, {r{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t          r_state;
  logic [r:0]      r_target;
  logic [IW-1:0]   r_idx;
  logic [n-1:0]    r_word;

  logic            w_xfer;
  logic [r:0]      w_target;
  logic [r:0]      w_count_nx;
  logic [n-1:0]    w_word;

  assign w_xfer     = bus.byte_valid & bus.byte_ready;
  assign w_target   = (num_words > DEPTH) ? DEPTH : num_words;
  assign w_count_nx = word_count + (r+1)'(1);
  assign cpu_run    = done;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_word = r_word;
    w_word[8*r_idx +: 8] = bus.byte_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_target       <= '0;
      r_idx          <= '0;
      r_word         <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      word_count     <= '0;
      checksum       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_target     <= w_target;
            r_idx        <= '0;
            word_count   <= '0;
            checksum     <= '0;
            bus.mem_addr <= '0;
            if (w_target == '0) begin
              r_state        <= S_DONE;
              done           <= 1'b1;
              busy           <= 1'b0;
              bus.byte_ready <= 1'b0;
            end else begin
              r_state        <= S_RECV;
              done           <= 1'b0;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (w_xfer) begin
            r_word <= w_word;
            if (r_idx == LAST_IDX) begin
              // The word is complete. Present it on the write port for exactly one cycle.
              r_idx          <= '0;
              r_state        <= S_WRITE;
              bus.byte_ready <= 1'b0;
              bus.mem_we     <= 1'b1;
              bus.mem_wdata  <= w_word;
              bus.mem_addr   <= word_count[r-1:0];
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          word_count <= w_count_nx;
          checksum   <= checksum ^ bus.mem_wdata;
          if (w_count_nx == r_target) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state        <= S_RECV;
            bus.byte_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. It drives inputs 1ns after the rising edge and samples on the falling edge.
// The expected words and checksums are worked out by hand or computed by a small local model.
module tb_imem_loader;
  localparam int N = 32;
  localparam int R = 6;

  typedef struct {
    logic [R-1:0] addr;
    logic [N-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [R:0]    num_words = '0;
  logic [R:0]    word_count;
  logic [N-1:0]  checksum;
  logic          busy, done, cpu_run;

  imem_loader_if #(.n(N), .r(R)) bus ();

  imem_loader #(.n(N), .r(R)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_words  (num_words),
    .bus        (bus.slave),
    .word_count (word_count),
    .checksum   (checksum),
    .busy       (busy),
    .done       (done),
    .cpu_run    (cpu_run)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  int  n_we     = 0;
  wr_t wlog[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // The write-port monitor logs every write and confirms that the loader never offers to take a byte while writing.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wlog.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
      n_we++;
      check("ready_in_write", bus.byte_ready, 0);
    end
  end

  task automatic do_start(input logic [R:0] nw);
    num_words = nw;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    forever begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) break;
      waited++;
      if (waited > 200) begin
        check("byte_accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      waited++;
      if (waited > 200) begin
        check("done_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  bus.byte_ready, 0);
    check({tag, "_we"},     bus.mem_we, 0);
    check({tag, "_addr"},   bus.mem_addr, 0);
    check({tag, "_wdata"},  bus.mem_wdata, 0);
    check({tag, "_count"},  word_count, 0);
    check({tag, "_csum"},   checksum, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_cpurun"}, cpu_run, 0);
  endtask

  task automatic check_deadbeef_load(input string tag);
    check({tag, "_nwr"},   wlog.size(), 2);
    if (wlog.size() == 2) begin
      check({tag, "_a0"}, wlog[0].addr, 0);
      check({tag, "_d0"}, wlog[0].data, 32'h12345678);
      check({tag, "_a1"}, wlog[1].addr, 1);
      check({tag, "_d1"}, wlog[1].data, 32'hDEADBEEF);
    end
    check({tag, "_count"}, word_count, 2);
    // The checksum is 12345678 XOR DEADBEEF, worked out one nibble at a time.
    check({tag, "_csum"},  checksum, 32'hCC99E897);
    check({tag, "_cpurun"}, cpu_run, 1);
  endtask

  logic [7:0] stream [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  int         gaps   [8] = '{1, 0, 3, 1, 0, 3, 1, 0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_csum;
    logic [N-1:0] exp_word;
    int           we_base;

    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: two words sent back-to-back.
    wlog.delete();
    do_start(2);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_ready", bus.byte_ready, 1);
    @(posedge clk); #1;
    foreach (stream[i]) send_byte(stream[i], 0);
    @(negedge clk);
    check("t1_we_last", bus.mem_we, 1);
    check("t1_done_early", done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_we_end", bus.mem_we, 0);
    check_deadbeef_load("t1");
    @(posedge clk); #1;

    // Test 2: the same stream with gaps. This start is issued from DONE, so the outputs must clear.
    wlog.delete();
    we_base = n_we;
    do_start(2);
    @(negedge clk);
    check("t2_done_clr", done, 0);
    check("t2_count_clr", word_count, 0);
    check("t2_csum_clr", checksum, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_byte(stream[i], gaps[i]);
    check("t2_no_early_we", n_we - we_base, 0);
    send_byte(stream[3], 0);
    @(negedge clk);
    check("t2_we_word0", bus.mem_we, 1);
    check("t2_wdata0", bus.mem_wdata, 32'h12345678);
    @(posedge clk); #1;
    for (int i = 4; i < 8; i++) send_byte(stream[i], gaps[i]);
    wait_done();
    check_deadbeef_load("t2");

    // Test 3: a request for zero words completes at once.
    we_base = n_we;
    do_start(0);
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_csum", checksum, 0);
    check("t3_count", word_count, 0);
    repeat (3) @(negedge clk);
    check("t3_no_we", n_we - we_base, 0);
    @(posedge clk); #1;

    // Test 4: 127 words requested with r=6, so the load is clamped to 64 words. Byte i carries the value i.
    wlog.delete();
    exp_csum = '0;
    do_start(127);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
    wait_done();
    we_base = n_we;
    check("t4_nwr", wlog.size(), 64);
    for (int k = 0; k < 64 && k < wlog.size(); k++) begin
      exp_word = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      exp_csum ^= exp_word;
      check($sformatf("t4_a%0d", k), wlog[k].addr, k);
      check($sformatf("t4_d%0d", k), wlog[k].data, exp_word);
    end
    check("t4_count", word_count, 64);
    check("t4_csum", checksum, exp_csum);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (4) @(negedge clk);
    check("t4_ready_held", bus.byte_ready, 0);
    check("t4_no_extra_we", n_we - we_base, 0);
    check("t4_still_done", done, 1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;

    // Test 5: reset arrives after six bytes of a three-word load.
    wlog.delete();
    do_start(3);
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
    we_base = n_we;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_one_write", n_we - we_base, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    wlog.delete();
    do_start(1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    wait_done();
    check("t5_nwr", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check("t5_a0", wlog[0].addr, 0);
      check("t5_d0", wlog[0].data, 32'h44332211);
    end
    check("t5_csum", checksum, 32'h44332211);
    check("t5_count", word_count, 1);

    // Test 6: a start issued during RECV is ignored. It asks for zero words, so honouring it would finish the load early.
    wlog.delete();
    do_start(2);
    send_byte(stream[0], 0);
    send_byte(stream[1], 0);
    do_start(0);
    @(negedge clk);
    check("t6_busy_kept", busy, 1);
    check("t6_done_low", done, 0);
    @(posedge clk); #1;
    for (int i = 2; i < 8; i++) send_byte(stream[i], 0);
    wait_done();
    check_deadbeef_load("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
